mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data-memory access controller for the 5-stage MIPS pipeline.
//  - Inputs: the instruction in EX/MEM.
//  - Drives a req/ack data-memory port; handles byte/half/word lanes and load extension.
//  - Stalls the pipeline while an access is outstanding.
//  - Presents AluRes/MemtoReg/RegWr plus load data to the MEM/WB register.
// PARAMETERS
//  TIMEOUT  255  max BUSY cycles without mem_ack before the access is aborted
//  CNT_W    8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, asynchronous, active-high
//  in_valid    in   1   EX/MEM holds a real instruction
//  mem_rd_i    in   1   load
//  mem_wr_i    in   1   store (mem_rd_i & mem_wr_i both set: treated as store)
//  size_i      in   2   00 byte, 01 half, 10/11 word
//  sext_i      in   1   load sign-extend (1) / zero-extend (0)
//  addr_i      in   32  byte address (ALU result)
//  wdata_i     in   32  store data, low-aligned
//  alures_i    in   32  ALU result
//  memtoreg_i  in   2   writeback select
//  regwr_i     in   1   register write enable
//  mem_req     out  1   memory request, held until ack
//  mem_we      out  1   1 = write
//  mem_addr    out  32  word address {addr_i[31:2],2'b00}
//  mem_be      out  4   byte enables, little-endian lanes
//  mem_wdata   out  32  lane-replicated store data
//  mem_rdata   in   32  read data, valid with mem_ack
//  mem_ack     in   1   one-cycle completion strobe
//  stall_o     out  1   freeze PC/IF-ID/ID-EX/EX-MEM; insert bubble into MEM/WB
//  alures_o    out  32  = alures_i
//  memtoreg_o  out  2   = memtoreg_i
//  regwr_o     out  1   regwr_i & ~stall_o & ~misalign_o & ~bus_err_o
//  ldata_o     out  32  extended load data (rdata_q)
//  misalign_o  out  1   combinational misalignment flag
//  bus_err_o   out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata = 0;
//   rdata_q, cnt, bus_err_o = 0. Asynchronous reset mid-access drops mem_req at once;
//   any later mem_ack is ignored in IDLE.
//  acc = in_valid & (mem_rd_i | mem_wr_i).
//  misalign = acc & ((size word & addr[1:0]!=0) | (size half & addr[0])).
//   No request is issued, no stall; regwr_o is forced 0.
//  FSM:
//   IDLE: acc & ~misalign -> BUSY. Register addr, be, wdata, we; set mem_req=1, cnt=0.
//         stall_o=1 in this cycle. Otherwise stall_o=0 (non-memory ops pass through).
//   BUSY: mem_req=1, outputs stable. stall_o=1.
//         mem_ack: load -> rdata_q <= extended mem_rdata. Clear mem_req. -> DONE.
//         else cnt==TIMEOUT: clear mem_req; bus_err_o=1 next cycle; -> DONE.
//         else cnt++.
//   DONE: stall_o=0; MEM/WB captures this edge. -> IDLE unconditionally.
//  Latency: 3 cycles minimum in MEM (issue, ack, DONE); +1 per wait cycle.
//  Lanes:
//   byte: be=1<<addr[1:0], wdata={4{wdata_i[7:0]}}
//   half: be=addr[1]?1100:0011, wdata={2{wdata_i[15:0]}}
//   word: be=1111
//  Load extract: byte lane addr[1:0] / halfword addr[1]; extend per sext_i.
//  mem_ack is ignored outside BUSY. Ack arriving on the timeout cycle: ack wins, no bus_err.
// TESTING
//  1. lw addr 0x100, ack after 2 wait cycles, mem_rdata 0xDEADBEEF
//     -> be=1111, stall 4 cycles, DONE: ldata_o=0xDEADBEEF, regwr_o=1.
//  2. lb sext addr 0x103, rdata 0x80xxxxxx -> be=1000, ldata_o=0xFFFFFF80;
//     lbu same -> 0x00000080.
//  3. sh addr 0x102, wdata 0x1234ABCD -> mem_we=1, be=1100,
//     mem_wdata=0xABCDABCD, mem_addr=0x100.
//  4. lw addr 0x101 -> misalign_o=1, mem_req stays 0, stall_o=0, regwr_o=0.
//  5. TIMEOUT=4, no ack -> mem_req drops after 5 BUSY cycles; bus_err_o pulses 1 cycle;
//     then IDLE.
//  6. Reset asserted in BUSY -> mem_req=0 immediately; later ack ignored; add/sub with
//     in_valid passes through with stall_o=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller for the 5-stage MIPS pipeline.
// Issues one req/ack transaction per load/store and stalls the pipeline until it
// completes. It also handles byte/half/word lanes, load extension and an access timeout.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] alures_i,
    input  logic [1:0]  memtoreg_i,
    input  logic        regwr_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_o,
    output logic [31:0] alures_o,
    output logic [1:0]  memtoreg_o,
    output logic        regwr_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    // Byte offset, size and extension mode of the access in flight, for load extraction.
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;

    logic              acc;
    logic              misalign;
    logic              is_byte;
    logic              is_half;
    logic              stall;
    logic [3:0]        be_lane;
    logic [31:0]       wdata_lane;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_ext;

    assign is_byte  = (size_i == 2'b00);
    assign is_half  = (size_i == 2'b01);
    assign acc      = in_valid & (mem_rd_i | mem_wr_i);
    assign misalign = acc & ((size_i[1] & (addr_i[1:0] != 2'b00)) | (is_half & addr_i[0]));

    // Store lane enables and lane-replicated write data for the current instruction.
    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = wdata_i;
        if (is_byte) begin
            be_lane    = 4'b0001 << addr_i[1:0];
            wdata_lane = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_lane    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata_i[15:0]}};
        end
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        ld_byte  = mem_rdata[7:0];
        case (off_q)
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            2'b11:   ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        if (size_q == 2'b00) begin
            load_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
        end else if (size_q == 2'b01) begin
            load_ext = {{16{sext_q & ld_half[15]}}, ld_half};
        end
    end

    // Access FSM: next state, registered bus outputs and stall.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
        off_d       = off_q;
        size_d      = size_q;
        sext_d      = sext_q;
        stall       = 1'b0;
        case (state_q)
            StIdle: begin
                if (acc && !misalign) begin
                    stall       = 1'b1;
                    state_d     = StBusy;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_wr_i;
                    mem_addr_d  = {addr_i[31:2], 2'b00};
                    mem_be_d    = be_lane;
                    mem_wdata_d = wdata_lane;
                    cnt_d       = '0;
                    off_d       = addr_i[1:0];
                    size_d      = size_i;
                    sext_d      = sext_i;
                end
            end
            StBusy: begin
                stall = 1'b1;
                // An ack on the timeout cycle still completes the access normally.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = load_ext;
                    end
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_q == TimeoutCnt) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; asynchronous reset drops any outstanding request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign stall_o    = stall;
    assign alures_o   = alures_i;
    assign memtoreg_o = memtoreg_i;
    assign regwr_o    = regwr_i & ~stall & ~misalign & ~bus_err_q;
    assign ldata_o    = rdata_q;
    assign misalign_o = misalign;
    assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues instructions and pushes
// expected bus requests and MEM/WB results; a monitor pops and compares them.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, mem_rd_i = 1'b0, mem_wr_i = 1'b0, sext_i = 1'b0, regwr_i = 1'b0;
    logic [1:0]  size_i = 2'b00, memtoreg_i = 2'b00;
    logic [31:0] addr_i = '0, wdata_i = '0, alures_i = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        stall_o, regwr_o, misalign_o, bus_err_o;
    logic [31:0] alures_o, ldata_o;
    logic [1:0]  memtoreg_o;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_rd_i(mem_rd_i),
        .mem_wr_i(mem_wr_i), .size_i(size_i), .sext_i(sext_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .alures_i(alures_i), .memtoreg_i(memtoreg_i), .regwr_i(regwr_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o),
        .alures_o(alures_o), .memtoreg_o(memtoreg_o), .regwr_o(regwr_o), .ldata_o(ldata_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        regwr;
        logic        misalign;
        logic        bus_err;
        logic        chk_ldata;
        logic [31:0] ldata;
        logic [31:0] alures;
        logic [1:0]  memtoreg;
        int          stall;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;
    bit          spur_ack = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after cur_delay wait cycles; spur_ack forces a stray ack.
    int wcnt = 0;
    always @(negedge clk) begin
        if (spur_ack) begin
            mem_ack   <= 1'b1;
            mem_rdata <= $urandom;
        end else if (!mem_req || mem_ack) begin
            mem_ack   <= 1'b0;
            mem_rdata <= $urandom;
            wcnt      <= 0;
        end else if (wcnt == cur_delay) begin
            mem_ack   <= 1'b1;
            mem_rdata <= cur_rdata;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Monitor: compares each new bus request and each MEM/WB capture against the queues.
    logic prev_req = 1'b0;
    int   stall_cnt = 0;
    req_t mr;
    res_t ms;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    mr = req_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(mr.we));
                    chk("mem_addr", mem_addr, mr.addr);
                    chk("mem_be", 32'(mem_be), 32'(mr.be));
                    if (mr.we) chk("mem_wdata", mem_wdata, mr.wdata);
                end
            end
            if (in_valid) begin
                if (stall_o) begin
                    stall_cnt++;
                    chk("bus_err_while_stalled", 32'(bus_err_o), 32'd0);
                end else if (res_q.size() == 0) begin
                    chk("unexpected_advance", 32'(stall_o), 32'd1);
                end else begin
                    ms = res_q.pop_front();
                    chk("stall_cycles", 32'(stall_cnt), 32'(ms.stall));
                    chk("regwr_o", 32'(regwr_o), 32'(ms.regwr));
                    chk("misalign_o", 32'(misalign_o), 32'(ms.misalign));
                    chk("bus_err_o", 32'(bus_err_o), 32'(ms.bus_err));
                    chk("alures_o", alures_o, ms.alures);
                    chk("memtoreg_o", 32'(memtoreg_o), 32'(ms.memtoreg));
                    if (ms.chk_ldata) chk("ldata_o", ldata_o, ms.ldata);
                    stall_cnt = 0;
                end
            end
        end
        prev_req = mem_req;
    end

    // Present one instruction, push its expectations, hold it until the pipeline advances.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] size, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, input bit rw);
        int unsigned nbytes, off;
        bit          acc, mis, tmo, adv;
        req_t        r;
        res_t        s;
        logic [31:0] sh, v;
        acc    = rd | wr;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off    = addr % 4;
        mis    = acc && ((addr % nbytes) != 0);
        tmo    = acc && !mis && (delay > int'(TO));
        if (acc && !mis) begin
            r.we    = wr;
            r.addr  = addr - off;
            r.be    = (nbytes == 1) ? 4'(1 << off) : (nbytes == 2) ? 4'(3 << off) : 4'hF;
            r.wdata = (nbytes == 1) ? wdata[7:0] * 32'h0101_0101 :
                      (nbytes == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
            req_q.push_back(r);
        end
        sh = rdata >> (8 * off);
        if (nbytes == 1) begin
            v = sh & 32'hFF;
            if (sext && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            v = sh & 32'hFFFF;
            if (sext && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        s.regwr     = rw && !mis && !tmo;
        s.misalign  = mis;
        s.bus_err   = tmo;
        s.chk_ldata = rd && !wr && !mis && !tmo;
        s.ldata     = v;
        s.alures    = $urandom;
        s.memtoreg  = 2'($urandom_range(0, 3));
        s.stall     = (!acc || mis) ? 0 : tmo ? int'(TO) + 2 : delay + 2;
        res_q.push_back(s);
        cur_delay  = delay;
        cur_rdata  = rdata;
        in_valid   = 1'b1;
        mem_rd_i   = rd;
        mem_wr_i   = wr;
        size_i     = size;
        sext_i     = sext;
        addr_i     = addr;
        wdata_i    = wdata;
        alures_i   = s.alures;
        memtoreg_i = s.memtoreg;
        regwr_i    = rw;
        adv = 1'b0;
        for (int i = 0; i < 50 && !adv; i++) begin
            @(negedge clk);
            adv = !stall_o;
            @(posedge clk);
            #1;
        end
        if (!adv) chk("advance_timeout", 32'(stall_o), 32'd0);
    endtask

    initial begin
        bit          rd, wr;
        logic [1:0]  sz;
        logic [31:0] a;
        int          d;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ldata", ldata_o, 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        issue(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 1);   // lw, 2 waits
        issue(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h8012_3456, 0, 1);   // lb sext
        issue(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h8012_3456, 1, 1);   // lbu
        issue(0, 1, 2'd1, 0, 32'h102, 32'h1234_ABCD, 32'h0, 1, 0);   // sh
        issue(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 1);           // misaligned lw
        issue(1, 0, 2'd1, 1, 32'h105, 32'h0, 32'h0, 0, 1);           // misaligned lh
        issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1000, 1);         // timeout
        issue(1, 0, 2'd1, 1, 32'h42, 32'h0, 32'h9ABC_1234, int'(TO), 1); // ack on timeout cycle
        issue(1, 1, 2'd3, 0, 32'h80, 32'hCAFE_F00D, 32'h0, 0, 1);    // rd+wr -> store
        issue(0, 0, 2'd0, 0, 32'h3, 32'h0, 32'h0, 0, 1);             // add passes through

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    begin rd = 0; wr = 0; end
                2, 3, 4: begin rd = 0; wr = 1; end
                9:       begin rd = 1; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 9) < 7) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
            d  = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, TO));
            issue(rd, wr, sz, 1'($urandom), a, $urandom, $urandom, d, 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);

        // Asynchronous reset in the middle of an access
        mon_en    = 1'b0;
        cur_delay = 1000;
        in_valid  = 1'b1;
        mem_rd_i  = 1'b1;
        mem_wr_i  = 1'b0;
        size_i    = 2'd2;
        addr_i    = 32'h200;
        repeat (3) @(posedge clk);
        #3;
        chk("busy_req_before_reset", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_drops_req", 32'(mem_req), 32'd0);
        mem_rd_i = 1'b0;
        regwr_i  = 1'b1;
        alures_i = 32'h1357_2468;
        @(negedge clk);
        reset    = 1'b0;
        spur_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("stray_ack_req", 32'(mem_req), 32'd0);
            chk("passthru_stall", 32'(stall_o), 32'd0);
            chk("passthru_regwr", 32'(regwr_o), 32'd1);
            chk("passthru_alures", alures_o, 32'h1357_2468);
            chk("stray_ack_ldata", ldata_o, 32'd0);
        end
        spur_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_no_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
